// File: rtl/sys_gpio_in_capture.sv
// Avalon-MM input PIO: synchronises in_port, latches per-bit edge events into
// a sticky capture register and drives a maskable, registered level interrupt.
module sys_gpio_in_capture #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam int unsigned PRIME_W    = 3;
  localparam int unsigned PRIME_INIT = SYNC_STAGES + 1;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [DATA_WIDTH-1:0] sync_stage_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [PRIME_W-1:0]    prime_q, prime_d;
  logic                  irq_q, irq_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rise, fall, ev, clr;

  assign sync_q = sync_stage_q[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;
  assign irq    = irq_q;

  // Edge detection, suppressed until the synchroniser and prev hold real samples
  always_comb begin
    rise = sync_q & ~prev_q;
    fall = ~sync_q & prev_q;
    if (EDGE_TYPE == 0)      ev = rise;
    else if (EDGE_TYPE == 1) ev = fall;
    else                     ev = rise | fall;
    if (prime_q != '0) ev = '0;
  end

  // Next-state for control registers; a new edge wins over a clear of the same bit
  always_comb begin
    mask_d  = mask_q;
    clr     = '0;
    prime_d = prime_q;
    if (wr_en && (address == ADDR_MASK)) mask_d = writedata[DATA_WIDTH-1:0];
    if (wr_en && (address == ADDR_CAP))  clr    = writedata[DATA_WIDTH-1:0];
    if (prime_q != '0) prime_d = prime_q - PRIME_W'(1);
    cap_d = (cap_q & ~clr) | ev;
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_stage_q[i] <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      prime_q <= PRIME_W'(PRIME_INIT);
      irq_q   <= 1'b0;
    end else begin
      sync_stage_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_stage_q[i] <= sync_stage_q[i-1];
      prev_q  <= sync_q;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      prime_q <= prime_d;
      irq_q   <= irq_d;
    end
  end

  // Zero-wait-state read mux; direction and unused upper bits read as zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(sync_q);
      ADDR_MASK: readdata = 32'(mask_q);
      ADDR_CAP:  readdata = 32'(cap_q);
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sys_gpio_in_capture.sv
// Directed bench for sys_gpio_in_capture: a rising-edge and an any-edge
// instance share one bus and input, expected values are hand-computed.
module tb_sys_gpio_in_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_gpio_in_capture #(.DATA_WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r),
    .in_port(in_port), .irq(irq_r)
  );

  sys_gpio_in_capture #(.DATA_WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .irq(irq_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] dr, output logic [31:0] da);
    address = a;
    #1;
    dr = rd_r;
    da = rd_a;
  endtask

  logic [31:0] vr, va;

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 32'hFFFF_FFFF;

    // Reset held with inputs high
    tick(3);
    bus_rd(2'd0, vr, va); chk("rst_data", vr, 32'h0);
    bus_rd(2'd3, vr, va); chk("rst_cap", vr, 32'h0);
    chk("rst_irq", {31'd0, irq_r}, 32'h0);

    // Release: high inputs must not capture
    reset = 1'b0;
    tick(10);
    bus_rd(2'd3, vr, va); chk("prime_cap_r", vr, 32'h0); chk("prime_cap_a", va, 32'h0);
    bus_rd(2'd0, vr, va); chk("prime_data", vr, 32'hFFFF_FFFF);
    chk("prime_irq", {31'd0, irq_r}, 32'h0);

    // All bits fall: only the any-edge instance captures
    in_port = 32'h0;
    tick(5);
    bus_rd(2'd3, vr, va); chk("fall_all_r", vr, 32'h0); chk("fall_all_a", va, 32'hFFFF_FFFF);
    chk("fall_all_irq_a", {31'd0, irq_a}, 32'h0);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd(2'd3, vr, va); chk("clr_all_a", va, 32'h0);

    // Bit0 rise latency with mask bit0
    bus_wr(2'd2, 32'h0000_0001);
    in_port = 32'h0000_0001;
    tick();  // E0
    bus_rd(2'd0, vr, va); chk("lat_e0_data", vr, 32'h0);
    tick();  // E1
    bus_rd(2'd0, vr, va); chk("lat_e1_data", vr, 32'h1);
    bus_rd(2'd3, vr, va); chk("lat_e1_cap", vr, 32'h0);
    tick();  // E2
    bus_rd(2'd3, vr, va); chk("lat_e2_cap", vr, 32'h1);
    chk("lat_e2_irq", {31'd0, irq_r}, 32'h0);
    tick();  // E3
    chk("lat_e3_irq", {31'd0, irq_r}, 32'h1);
    bus_wr(2'd3, 32'h0000_0001);
    bus_rd(2'd3, vr, va); chk("clr0_cap", vr, 32'h0);
    chk("clr0_irq_hold", {31'd0, irq_r}, 32'h1);
    tick();
    chk("clr0_irq_drop", {31'd0, irq_r}, 32'h0);

    // Bit5 falling edge: ignored by rising instance, caught by any-edge
    in_port = 32'h0000_0021;
    tick(5);
    bus_wr(2'd3, 32'h0000_0020);
    in_port = 32'h0000_0001;
    tick(5);
    bus_rd(2'd3, vr, va); chk("fall5_r", vr, 32'h0); chk("fall5_a", va, 32'h0000_0020);
    bus_wr(2'd3, 32'hFFFF_FFFF);

    // Clear and new edge on bit3 in the same cycle: set wins
    bus_wr(2'd2, 32'h0000_0008);
    in_port = 32'h0000_0009;
    tick(2);                     // E0, E1: edge now pending on ev
    bus_wr(2'd3, 32'h0000_0008); // lands on E2
    bus_rd(2'd3, vr, va); chk("setwins_cap", vr, 32'h0000_0008);
    tick();
    chk("setwins_irq", {31'd0, irq_r}, 32'h1);
    tick(3);
    chk("setwins_irq_hold", {31'd0, irq_r}, 32'h1);
    bus_rd(2'd3, vr, va); chk("setwins_cap_hold", vr, 32'h0000_0008);
    bus_wr(2'd3, 32'h0000_0008);
    tick();
    chk("setwins_irq_clr", {31'd0, irq_r}, 32'h0);

    // Pending 0xF0 with mask 0, then unmask bit4, then clear bit4
    bus_wr(2'd2, 32'h0);
    in_port = 32'h0000_00F9;
    tick(6);
    bus_rd(2'd3, vr, va); chk("pend_cap", vr, 32'h0000_00F0);
    chk("pend_irq_masked", {31'd0, irq_r}, 32'h0);
    bus_wr(2'd2, 32'h0000_0010);
    chk("pend_irq_e0", {31'd0, irq_r}, 32'h0);
    tick();
    chk("pend_irq_unmask", {31'd0, irq_r}, 32'h1);
    bus_wr(2'd3, 32'h0000_0010);
    tick();
    chk("pend_irq_clr", {31'd0, irq_r}, 32'h0);
    bus_rd(2'd3, vr, va); chk("pend_cap_after", vr, 32'h0000_00E0);

    // Writes to data and direction are ignored
    bus_wr(2'd0, 32'hDEAD_BEEF);
    bus_wr(2'd1, 32'hDEAD_BEEF);
    bus_rd(2'd0, vr, va); chk("ro_data", vr, 32'h0000_00F9);
    bus_rd(2'd1, vr, va); chk("ro_dir", vr, 32'h0);
    bus_rd(2'd2, vr, va); chk("ro_mask", vr, 32'h0000_0010);
    bus_rd(2'd3, vr, va); chk("ro_cap", vr, 32'h0000_00E0);

    // Reset mid-operation overrides a concurrent mask write
    bus_wr(2'd2, 32'h0000_00E0);
    tick();
    chk("mid_irq_pre", {31'd0, irq_r}, 32'h1);
    reset = 1'b1;
    bus_wr(2'd2, 32'hFFFF_FFFF);
    reset = 1'b0;
    bus_rd(2'd2, vr, va); chk("mid_mask", vr, 32'h0);
    bus_rd(2'd3, vr, va); chk("mid_cap", vr, 32'h0);
    chk("mid_irq", {31'd0, irq_r}, 32'h0);
    tick(8);
    bus_rd(2'd3, vr, va); chk("mid_prime_r", vr, 32'h0); chk("mid_prime_a", va, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
